// File: rtl/udp_stream_pkg.sv
// Shared types and defaults for the UDP receive stream path.
package udp_stream_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 512;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  // Packet filter FSM states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PASS = 2'd1,
    S_DROP = 2'd2
  } state_t;

  // Per-packet metadata carried alongside every stored beat.
  typedef struct packed {
    logic [31:0] ip;
    logic [15:0] rport;
    logic [15:0] lport;
  } meta_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/axis_meta_fifo.sv
// First-word-fall-through beat buffer holding {TDATA, TKEEP, TLAST, metadata}.
// Pointers carry one extra bit so full and empty are distinguishable.
module axis_meta_fifo
  import udp_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int unsigned KEEP_W = DATA_WIDTH / 8,
  localparam int unsigned AW     = $clog2(FIFO_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_aresetn,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [KEEP_W-1:0]     i_keep,
  input  logic                  i_last,
  input  meta_t                 i_meta,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [KEEP_W-1:0]     o_keep,
  output logic                  o_last,
  output meta_t                 o_meta,
  output logic                  o_empty,
  output logic [AW:0]           o_count
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [KEEP_W-1:0]     r_mem_keep [FIFO_DEPTH];
  logic                  r_mem_last [FIFO_DEPTH];
  meta_t                 r_mem_meta [FIFO_DEPTH];

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_empty;
  logic        w_full;
  logic        w_do_push;
  logic        w_do_pop;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;

  // Storage write; payload memory needs no reset since empty masks it.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem_data[r_wptr[AW-1:0]] <= i_data;
      r_mem_keep[r_wptr[AW-1:0]] <= i_keep;
      r_mem_last[r_wptr[AW-1:0]] <= i_last;
      r_mem_meta[r_wptr[AW-1:0]] <= i_meta;
    end
  end

  // Read/write pointer advance; reset flushes any buffered beats.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  assign o_data  = r_mem_data[r_rptr[AW-1:0]];
  assign o_keep  = r_mem_keep[r_rptr[AW-1:0]];
  assign o_last  = r_mem_last[r_rptr[AW-1:0]];
  assign o_meta  = r_mem_meta[r_rptr[AW-1:0]];
  assign o_empty = w_empty;
  assign o_count = r_wptr - r_rptr;

endmodule

// File: rtl/udp_rx_port_filter.sv
// UDP receive port filter: forwards packets whose local port matches the
// listen port (0 = accept all), drops the rest, and counts both.
//
// state  | meaning
// S_IDLE | awaiting first beat of a packet; port decision made here
// S_PASS | forwarding remaining beats with metadata latched at first beat
// S_DROP | discarding remaining beats of a rejected packet
module udp_rx_port_filter
  import udp_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_aresetn,
  input  logic                    i_input_TVALID,
  output logic                    o_input_TREADY,
  input  logic [DATA_WIDTH-1:0]   i_input_TDATA,
  input  logic [DATA_WIDTH/8-1:0] i_input_TKEEP,
  input  logic                    i_input_TLAST,
  input  logic [31:0]             i_remote_ip_rx,
  input  logic [15:0]             i_remote_port_rx,
  input  logic [15:0]             i_local_port_rx,
  input  logic [15:0]             i_listen_port,
  output logic                    o_output_TVALID,
  input  logic                    i_output_TREADY,
  output logic [DATA_WIDTH-1:0]   o_output_TDATA,
  output logic [DATA_WIDTH/8-1:0] o_output_TKEEP,
  output logic                    o_output_TLAST,
  output logic [31:0]             o_remote_ip_rx,
  output logic [15:0]             o_remote_port_rx,
  output logic [15:0]             o_local_port_rx,
  output logic [31:0]             o_pkt_count,
  output logic [31:0]             o_drop_count
);

  localparam int unsigned AW          = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LP_FULL_CNT = (AW+1)'(FIFO_DEPTH);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_in_ready;
  meta_t       r_meta;
  logic [31:0] r_pkt_count;
  logic [31:0] r_drop_count;

  meta_t       w_meta_live;
  meta_t       w_meta_push;
  meta_t       w_meta_head;
  logic        w_accept;
  logic        w_match;
  logic        w_push;
  logic        w_latch;
  logic        w_inc_pkt;
  logic        w_inc_drop;
  logic        w_empty;
  logic        w_pop;
  logic [AW:0] w_occ;
  logic [AW:0] w_occ_nxt;
  logic        w_ready_nxt;

  assign w_accept = i_input_TVALID && r_in_ready;
  assign w_match  = (i_listen_port == 16'd0) || (i_local_port_rx == i_listen_port);
  assign w_pop    = !w_empty && i_output_TREADY;

  always_comb begin
    w_meta_live       = '0;
    w_meta_live.ip    = i_remote_ip_rx;
    w_meta_live.rport = i_remote_port_rx;
    w_meta_live.lport = i_local_port_rx;
  end

  // Next-state and per-beat actions; the listen port is only consulted on a first beat.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_latch     = 1'b0;
    w_inc_pkt   = 1'b0;
    w_inc_drop  = 1'b0;
    w_meta_push = r_meta;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_match) begin
            w_push      = 1'b1;
            w_latch     = 1'b1;
            w_inc_pkt   = 1'b1;
            w_meta_push = w_meta_live;
            if (!i_input_TLAST) w_state_nxt = S_PASS;
          end else begin
            w_inc_drop = 1'b1;
            if (!i_input_TLAST) w_state_nxt = S_DROP;
          end
        end
      end
      S_PASS: begin
        if (w_accept) begin
          w_push = 1'b1;
          if (i_input_TLAST) w_state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        if (w_accept && i_input_TLAST) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ready is registered from next-cycle occupancy so it never follows downstream ready combinationally.
  always_comb begin
    w_occ_nxt   = w_occ + (AW+1)'(w_push) - (AW+1)'(w_pop);
    w_ready_nxt = (w_state_nxt == S_DROP) || (w_occ_nxt != LP_FULL_CNT);
  end

  // State, ready, latched metadata and saturating counters.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b0;
      r_meta       <= '0;
      r_pkt_count  <= '0;
      r_drop_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= w_ready_nxt;
      if (w_latch)    r_meta       <= w_meta_live;
      if (w_inc_pkt)  r_pkt_count  <= sat_inc(r_pkt_count);
      if (w_inc_drop) r_drop_count <= sat_inc(r_drop_count);
    end
  end

  axis_meta_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_aresetn (i_aresetn),
    .i_push    (w_push),
    .i_data    (i_input_TDATA),
    .i_keep    (i_input_TKEEP),
    .i_last    (i_input_TLAST),
    .i_meta    (w_meta_push),
    .i_pop     (w_pop),
    .o_data    (o_output_TDATA),
    .o_keep    (o_output_TKEEP),
    .o_last    (o_output_TLAST),
    .o_meta    (w_meta_head),
    .o_empty   (w_empty),
    .o_count   (w_occ)
  );

  assign o_input_TREADY   = r_in_ready;
  assign o_output_TVALID  = !w_empty;
  assign o_remote_ip_rx   = w_meta_head.ip;
  assign o_remote_port_rx = w_meta_head.rport;
  assign o_local_port_rx  = w_meta_head.lport;
  assign o_pkt_count      = r_pkt_count;
  assign o_drop_count     = r_drop_count;

endmodule

// File: tb/tb_udp_rx_port_filter.sv
// Testbench for udp_rx_port_filter: table vectors, directed corner sequences
// and a randomized run against a queue-based packet model.
module tb_udp_rx_port_filter;

  localparam int DW    = 512;
  localparam int KW    = DW / 8;
  localparam int DEPTH = 4;

  logic           i_clk = 1'b0;
  logic           i_aresetn;
  logic           i_input_TVALID;
  logic           o_input_TREADY;
  logic [DW-1:0]  i_input_TDATA;
  logic [KW-1:0]  i_input_TKEEP;
  logic           i_input_TLAST;
  logic [31:0]    i_remote_ip_rx;
  logic [15:0]    i_remote_port_rx;
  logic [15:0]    i_local_port_rx;
  logic [15:0]    i_listen_port;
  logic           o_output_TVALID;
  logic           i_output_TREADY;
  logic [DW-1:0]  o_output_TDATA;
  logic [KW-1:0]  o_output_TKEEP;
  logic           o_output_TLAST;
  logic [31:0]    o_remote_ip_rx;
  logic [15:0]    o_remote_port_rx;
  logic [15:0]    o_local_port_rx;
  logic [31:0]    o_pkt_count;
  logic [31:0]    o_drop_count;

  always #5 i_clk = ~i_clk;

  udp_rx_port_filter #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk            (i_clk),
    .i_aresetn        (i_aresetn),
    .i_input_TVALID   (i_input_TVALID),
    .o_input_TREADY   (o_input_TREADY),
    .i_input_TDATA    (i_input_TDATA),
    .i_input_TKEEP    (i_input_TKEEP),
    .i_input_TLAST    (i_input_TLAST),
    .i_remote_ip_rx   (i_remote_ip_rx),
    .i_remote_port_rx (i_remote_port_rx),
    .i_local_port_rx  (i_local_port_rx),
    .i_listen_port    (i_listen_port),
    .o_output_TVALID  (o_output_TVALID),
    .i_output_TREADY  (i_output_TREADY),
    .o_output_TDATA   (o_output_TDATA),
    .o_output_TKEEP   (o_output_TKEEP),
    .o_output_TLAST   (o_output_TLAST),
    .o_remote_ip_rx   (o_remote_ip_rx),
    .o_remote_port_rx (o_remote_port_rx),
    .o_local_port_rx  (o_local_port_rx),
    .o_pkt_count      (o_pkt_count),
    .o_drop_count     (o_drop_count)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [63:0]   meta;   // {ip, rport, lport}
  } beat_t;

  beat_t       q[$];       // beats expected downstream, in order
  int          m_mode;     // 0 first beat expected, 1 forwarding, 2 discarding
  logic [63:0] m_meta;
  logic [31:0] m_pkt;
  logic [31:0] m_drop;
  bit          m_ready;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("in_ready",   DW'(o_input_TREADY),  DW'(m_ready));
    check("out_valid",  DW'(o_output_TVALID), DW'(q.size() > 0));
    check("pkt_count",  DW'(o_pkt_count),     DW'(m_pkt));
    check("drop_count", DW'(o_drop_count),    DW'(m_drop));
    if (q.size() > 0) begin
      check("out_data", o_output_TDATA,      q[0].data);
      check("out_keep", DW'(o_output_TKEEP), DW'(q[0].keep));
      check("out_last", DW'(o_output_TLAST), DW'(q[0].last));
      check("out_meta", DW'({o_remote_ip_rx, o_remote_port_rx, o_local_port_rx}), DW'(q[0].meta));
    end
  endtask

  function automatic logic [31:0] bump(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // One clock: model the edge from the current inputs, advance, then compare.
  task automatic tick();
    bit    acc;
    bit    pop;
    beat_t b;
    acc = i_input_TVALID && m_ready;
    pop = (q.size() > 0) && i_output_TREADY;
    if (pop) b = q.pop_front();
    if (acc) begin
      b.data = i_input_TDATA;
      b.keep = i_input_TKEEP;
      b.last = i_input_TLAST;
      if (m_mode == 0) begin
        if (i_listen_port == 16'd0 || i_local_port_rx == i_listen_port) begin
          m_meta = {i_remote_ip_rx, i_remote_port_rx, i_local_port_rx};
          b.meta = m_meta;
          q.push_back(b);
          m_pkt  = bump(m_pkt);
          m_mode = i_input_TLAST ? 0 : 1;
        end else begin
          m_drop = bump(m_drop);
          m_mode = i_input_TLAST ? 0 : 2;
        end
      end else if (m_mode == 1) begin
        b.meta = m_meta;
        q.push_back(b);
        if (i_input_TLAST) m_mode = 0;
      end else begin
        if (i_input_TLAST) m_mode = 0;
      end
    end
    m_ready = (m_mode == 2) || (q.size() < DEPTH);
    @(posedge i_clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    i_input_TVALID = 1'b0;
    i_aresetn      = 1'b0;
    q.delete();
    m_mode  = 0;
    m_meta  = '0;
    m_pkt   = '0;
    m_drop  = '0;
    m_ready = 1'b0;
    #2;
    compare_all();
    @(posedge i_clk);
    #1;
    compare_all();
    i_aresetn = 1'b1;
    tick();
  endtask

  task automatic drive(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                       input logic [31:0] ip, input logic [15:0] rp, input logic [15:0] lp);
    i_input_TVALID   = 1'b1;
    i_input_TDATA    = d;
    i_input_TKEEP    = k;
    i_input_TLAST    = l;
    i_remote_ip_rx   = ip;
    i_remote_port_rx = rp;
    i_local_port_rx  = lp;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  typedef struct {
    logic [15:0] listen;
    logic [15:0] lport;
    bit          pass;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] c_data;
    int            accepted;
    int            drained;
    int            idx;
    logic [15:0]   lports[4];

    vecs[0] = '{16'd500,   16'd500,   1'b1};
    vecs[1] = '{16'd500,   16'd200,   1'b0};
    vecs[2] = '{16'd0,     16'd200,   1'b1};
    vecs[3] = '{16'd0,     16'd750,   1'b1};
    vecs[4] = '{16'd1,     16'd0,     1'b0};
    vecs[5] = '{16'd65535, 16'd65535, 1'b1};
    vecs[6] = '{16'd65535, 16'd65534, 1'b0};
    vecs[7] = '{16'd750,   16'd751,   1'b0};

    lports[0] = 16'd500; lports[1] = 16'd200; lports[2] = 16'd750; lports[3] = 16'd0;

    i_input_TVALID   = 1'b0;
    i_input_TDATA    = '0;
    i_input_TKEEP    = '0;
    i_input_TLAST    = 1'b0;
    i_remote_ip_rx   = '0;
    i_remote_port_rx = '0;
    i_local_port_rx  = '0;
    i_listen_port    = 16'd500;
    i_output_TREADY  = 1'b1;
    i_aresetn        = 1'b1;
    #3;

    // Reset state
    do_reset();
    check("rst_ready_up", DW'(o_input_TREADY), DW'(1));

    // Single-beat packet forwarded unchanged
    c_data = {8'h02, 248'h0, 32'h863787d9, 224'h0};
    i_listen_port   = 16'd500;
    i_output_TREADY = 1'b0;
    drive(c_data, 64'h8000_0000_0000_0000, 1'b1, 32'd15000, 16'd1000, 16'd500);
    tick();
    i_input_TVALID = 1'b0;
    check("p1_valid", DW'(o_output_TVALID), DW'(1));
    check("p1_data",  o_output_TDATA, c_data);
    check("p1_keep",  DW'(o_output_TKEEP), DW'(64'h8000_0000_0000_0000));
    check("p1_last",  DW'(o_output_TLAST), DW'(1));
    check("p1_meta",  DW'({o_remote_ip_rx, o_remote_port_rx, o_local_port_rx}),
          DW'({32'd15000, 16'd1000, 16'd500}));
    check("p1_pkt",   DW'(o_pkt_count), DW'(1));
    i_output_TREADY = 1'b1;
    tick();
    check("p1_popped", DW'(o_output_TVALID), DW'(0));

    // Mismatched single beat dropped
    drive(rand_data(), '1, 1'b1, 32'd15000, 16'd1000, 16'd200);
    tick();
    i_input_TVALID = 1'b0;
    check("drop_valid", DW'(o_output_TVALID), DW'(0));
    check("drop_cnt",   DW'(o_drop_count), DW'(1));
    check("drop_ready", DW'(o_input_TREADY), DW'(1));

    // Multi-beat packet: later metadata ignored, TLAST only on the final beat
    for (int n = 1; n <= 3; n++) begin
      if (n == 1) drive(rand_data(), '1, 1'b0, 32'd15000, 16'd1000, 16'd500);
      else        drive(rand_data(), '1, n == 3, 32'd77 + n, 16'd9, 16'd7);
      tick();
      check("mb_meta", DW'({o_remote_ip_rx, o_remote_port_rx, o_local_port_rx}),
            DW'({32'd15000, 16'd1000, 16'd500}));
      check("mb_last", DW'(o_output_TLAST), DW'(n == 3));
    end
    i_input_TVALID = 1'b0;
    tick();

    // Backpressure: 6 beats offered into a 4-deep buffer
    i_output_TREADY = 1'b0;
    accepted = 0;
    for (int c = 0; c < 6; c++) begin
      idx = accepted;
      drive(DW'(idx + 100), KW'(idx + 1), idx == 5, 32'd15000, 16'd1000, 16'd500);
      if (o_input_TREADY) accepted++;
      tick();
    end
    check("bp_accepted", DW'(accepted), DW'(4));
    check("bp_ready",    DW'(o_input_TREADY), DW'(0));
    i_output_TREADY = 1'b1;
    drained = 0;
    for (int c = 0; c < 20 && drained < 6; c++) begin
      if (accepted < 6) begin
        drive(DW'(accepted + 100), KW'(accepted + 1), accepted == 5, 32'd15000, 16'd1000, 16'd500);
      end else begin
        i_input_TVALID = 1'b0;
      end
      if (o_output_TVALID) begin
        check("bp_order", o_output_TDATA, DW'(drained + 100));
        drained++;
      end
      if (i_input_TVALID && o_input_TREADY) accepted++;
      tick();
    end
    i_input_TVALID = 1'b0;
    check("bp_drained", DW'(drained), DW'(6));

    // Listen-all
    do_reset();
    i_listen_port = 16'd0;
    drive(rand_data(), '1, 1'b1, 32'd1, 16'd2, 16'd200);
    tick();
    drive(rand_data(), '1, 1'b1, 32'd3, 16'd4, 16'd750);
    tick();
    i_input_TVALID = 1'b0;
    tick();
    check("any_pkt", DW'(o_pkt_count), DW'(2));

    // Reset in the middle of a packet flushes it
    i_listen_port   = 16'd500;
    i_output_TREADY = 1'b0;
    drive(rand_data(), '1, 1'b0, 32'd15000, 16'd1000, 16'd500);
    tick();
    drive(rand_data(), '1, 1'b0, 32'd15000, 16'd1000, 16'd500);
    tick();
    do_reset();
    check("mr_valid", DW'(o_output_TVALID), DW'(0));
    check("mr_pkt",   DW'(o_pkt_count), DW'(0));
    check("mr_drop",  DW'(o_drop_count), DW'(0));
    i_output_TREADY = 1'b1;
    drive(c_data, '1, 1'b1, 32'd5, 16'd6, 16'd500);
    tick();
    i_input_TVALID = 1'b0;
    check("mr_next_valid", DW'(o_output_TVALID), DW'(1));
    check("mr_next_data",  o_output_TDATA, c_data);
    check("mr_next_last",  DW'(o_output_TLAST), DW'(1));
    tick();

    // Table of single-beat port decisions
    foreach (vecs[i]) begin
      i_listen_port = vecs[i].listen;
      drive(rand_data(), '1, 1'b1, $urandom, 16'($urandom), vecs[i].lport);
      tick();
      i_input_TVALID = 1'b0;
      check("tbl_pass", DW'(o_output_TVALID), DW'(vecs[i].pass));
      tick();
    end

    // Randomized traffic against the model
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 40) == 0) i_listen_port = lports[$urandom_range(0, 2)];
      i_input_TVALID   = ($urandom_range(0, 3) != 0);
      i_input_TDATA    = rand_data();
      i_input_TKEEP    = {$urandom, $urandom};
      i_input_TLAST    = ($urandom_range(0, 2) == 0);
      i_remote_ip_rx   = $urandom;
      i_remote_port_rx = 16'($urandom);
      i_local_port_rx  = lports[$urandom_range(0, 3)];
      i_output_TREADY  = ($urandom_range(0, 2) != 0);
      tick();
    end
    i_input_TVALID  = 1'b0;
    i_output_TREADY = 1'b1;
    for (int c = 0; c < 8; c++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/udp_rx_port_filter.md
UDP_RX_PORT_FILTER -- requirements
Module: udp_rx_port_filter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, stream data width in bits (multiple of 8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, beat buffer depth (power of two, >=2).
REQ-003 SHALL have ports, in order: i_clk  in  1  single clock.
REQ-004 i_aresetn  in  1  asynchronous active-low reset.
REQ-005 i_input_TVALID / o_input_TREADY  in/out  1  upstream AXI4-Stream handshake.
REQ-006 i_input_TDATA  in  DATA_WIDTH; i_input_TKEEP  in  DATA_WIDTH/8; i_input_TLAST  in  1.
REQ-007 i_remote_ip_rx  in  32; i_remote_port_rx  in  16; i_local_port_rx  in  16  packet metadata, valid with first beat.
REQ-008 i_listen_port  in  16  accepted local port; 0 means accept all.
REQ-009 o_output_TVALID / i_output_TREADY  out/in  1  downstream handshake to test_hardware_server input.
REQ-010 o_output_TDATA  out  DATA_WIDTH; o_output_TKEEP  out  DATA_WIDTH/8; o_output_TLAST  out  1.
REQ-011 o_remote_ip_rx  out  32; o_remote_port_rx  out  16; o_local_port_rx  out  16  metadata of current output beat.
REQ-012 o_pkt_count  out  32  packets passed; o_drop_count  out  32  packets dropped.

Function
REQ-013 Input beat accepted SHALL mean i_input_TVALID & o_input_TREADY at i_clk rising edge; output beat likewise with i_output_TREADY.
REQ-014 FSM states SHALL be S_IDLE (awaiting first beat), S_PASS (forwarding remainder), S_DROP (discarding remainder).
REQ-015 In S_IDLE, accepted beat SHALL match when i_listen_port==0 or i_local_port_rx==i_listen_port.
REQ-016 Match: beat + all three metadata fields written to FIFO, metadata latched, o_pkt_count +1; TLAST=0 -> S_PASS, TLAST=1 -> stay S_IDLE.
REQ-017 Mismatch: beat discarded, o_drop_count +1; TLAST=0 -> S_DROP, TLAST=1 -> stay S_IDLE.
REQ-018 In S_PASS, beats SHALL be written with latched metadata (live metadata ignored); TLAST=1 -> S_IDLE.
REQ-019 In S_DROP, beats SHALL be discarded without counting; TLAST=1 -> S_IDLE.
REQ-020 o_input_TREADY SHALL be 1 in S_DROP, else registered !full; never combinationally dependent on i_output_TREADY.
REQ-021 FIFO SHALL be first-word-fall-through: o_output_TVALID = !empty, outputs driven from head entry.
REQ-022 Latency SHALL be one cycle: beat accepted at edge N is visible on output after edge N (if FIFO was empty).
REQ-023 Simultaneous push and pop SHALL keep occupancy unchanged, including at full (push permitted only if TREADY was asserted).
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH using one extra bit for full/empty distinction.
REQ-025 Output fields SHALL remain stable while o_output_TVALID=1 and i_output_TREADY=0.
REQ-026 Counters SHALL saturate at 0xFFFFFFFF, never wrap.
REQ-027 i_listen_port changes SHALL take effect only at the next S_IDLE first beat.

Reset
REQ-028 On i_aresetn=0 (asynchronous): FSM -> S_IDLE, FIFO empty, o_output_TVALID=0, o_input_TREADY=0, counters=0, latched metadata=0.
REQ-029 o_input_TREADY SHALL rise on the first edge after reset release; reset mid-packet SHALL flush partial packet without output.

Structure
REQ-030 Shared package udp_stream_pkg SHALL hold FSM state typedef, metadata struct (ip, remote port, local port) and default widths.
REQ-031 FIFO SHALL be one sub-module, axis_meta_fifo, storing {TDATA, TKEEP, TLAST, metadata}.

Verification
REQ-032 Listen 500; single-beat packet TDATA=0x02..863787d9.., TKEEP=0x8000000000000000, ip 15000, rport 1000, lport 500 -> identical beat and metadata out, o_pkt_count=1.
REQ-033 Listen 500; single beat with lport 200 -> no output, o_drop_count=1, TREADY stays 1.
REQ-034 Listen 500; 3-beat packet lport 500, metadata changed on beats 2-3 -> all 3 beats carry ip 15000/1000/500, TLAST only on beat 3.
REQ-035 i_output_TREADY=0, 6 beats offered -> exactly 4 accepted, TREADY=0; then TREADY=1 -> all 6 out in order, no loss/duplication.
REQ-036 Listen 0; packets with lport 200 and 750 -> both passed, o_pkt_count=2.
REQ-037 Reset asserted after beat 2 of a 4-beat packet -> FIFO empty, counters 0, next packet passes cleanly.
